// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: program word stream plus instruction RAM address/write port of the boot loader
interface imem_boot_loader_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] cpu_a;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    modport master (output in_valid, in_data, in_last, cpu_a, input in_ready, mem_a, mem_we, mem_wd);
    modport slave (input in_valid, in_data, in_last, cpu_a, output in_ready, mem_a, mem_we, mem_wd);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into instruction RAM, NOP-fills the tail, then releases the core
module imem_boot_loader #(
    parameter int DEPTH = 64,
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    imem_boot_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [AW:0]       word_count
);
    typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, ERROR} state_e;
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          at_end;
    assign at_end = ptr_q == AW'(DEPTH - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            LOAD: if (bus.in_valid) begin
                ptr_d   = ptr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = bus.in_last ? (at_end ? RUN : FILL) : (at_end ? ERROR : LOAD);
                err_d   = !bus.in_last && at_end;
            end
            FILL: begin
                ptr_d   = ptr_q + 1'b1;
                state_d = at_end ? RUN : FILL;
            end
            // IDLE, RUN and ERROR all restart the same way
            default: if (start) begin
                state_d = LOAD;
                ptr_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end
    always_comb begin
        cpu_hold     = state_q != RUN;
        done         = state_q == RUN;
        bus.in_ready = state_q == LOAD;
        bus.mem_a    = state_q == RUN ? bus.cpu_a : ptr_q;
        bus.mem_we   = (state_q == LOAD && bus.in_valid) || state_q == FILL;
        bus.mem_wd   = state_q == LOAD ? bus.in_data : '0;
        err          = err_q;
        word_count   = cnt_q;
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven and randomized load sequences checked against a program-level RAM/timing model
module tb_imem_boot_loader;
    typedef struct {
        int n;
        bit last;
        int bub;
        bit junk;
        bit exp_err;
        int exp_wc;
        int exp_edges;
    } vec_t;
    logic        clk = 0;
    logic        reset_n;
    logic        start;
    logic        cpu_hold, done, err;
    logic [6:0]  word_count;
    logic [31:0] prog [64];
    logic [31:0] ram [64];
    int          total = 0;
    int          bad = 0;
    vec_t        vt [7];
    imem_boot_loader_if #(.AW(6), .DW(32)) itf ();
    imem_boot_loader #(.DEPTH(64), .AW(6), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(itf),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask
    // called on every falling edge of a load: captures what the RAM would store at the next rising edge
    task automatic sample(inout int wr);
        if (itf.mem_we === 1'b1) begin
            ram[itf.mem_a] = itf.mem_wd;
            wr++;
        end
    endtask
    task automatic load_and_check(input vec_t v);
        int idx, edges, bubbles, wr, mism, exp_e;
        bit tog, val;
        logic [31:0] ew;
        for (int i = 0; i < 64; i++) ram[i] = 32'hdeadbeef;
        idx = 0; edges = 0; bubbles = 0; wr = 0; tog = 0;
        start = 1; itf.in_valid = 1; itf.in_data = 32'hbad0bad0; itf.in_last = 1;
        @(negedge clk);
        sample(wr);
        chk("start_cycle_we", itf.mem_we, 0);
        chk("start_cycle_ready", itf.in_ready, 0);
        @(posedge clk); #1;
        start = 0;
        chk("hold_after_start", cpu_hold, 1);
        chk("done_after_start", done, 0);
        chk("ready_after_start", itf.in_ready, 1);
        do begin
            if (idx < v.n) begin
                val = v.bub == 0 ? 1'b1 : v.bub == 1 ? tog : ($urandom_range(0, 2) != 0);
                tog = !tog;
                itf.in_data = prog[idx];
                itf.in_last = v.last && idx == v.n - 1;
                if (!val) bubbles++;
            end else begin
                val = 1'($urandom_range(0, 1));
                itf.in_data = $urandom;
                itf.in_last = 1'($urandom_range(0, 1));
            end
            itf.in_valid = val;
            start = v.junk ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            sample(wr);
            if (idx < v.n && !val) chk("bubble_no_write", itf.mem_we, 0);
            @(posedge clk); #1;
            edges++;
            if (idx < v.n && val) idx++;
        end while (!(done || err) && edges < 300);
        start = 0; itf.in_valid = 0; itf.in_last = 0;
        exp_e = v.exp_edges < 0 ? 64 + bubbles : v.exp_edges;
        chk("edges_to_end", edges, exp_e);
        chk("err", err, v.exp_err);
        chk("done", done, !v.exp_err);
        chk("cpu_hold", cpu_hold, v.exp_err);
        chk("in_ready_end", itf.in_ready, 0);
        chk("word_count", word_count, v.exp_wc);
        chk("write_cycles", wr, 64);
        mism = 0;
        for (int i = 0; i < 64; i++) begin
            ew = i < v.n ? prog[i] : 32'h0;
            if (ram[i] !== ew) mism++;
        end
        chk("ram_bad_words", mism, 0);
        if (!v.exp_err) begin
            itf.cpu_a = 6'($urandom);
            #1 chk("mem_a_follows_cpu_a", itf.mem_a, itf.cpu_a);
            @(posedge clk); #1;
        end else begin
            itf.in_valid = 1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("err_no_write", itf.mem_we, 0);
            chk("err_ready", itf.in_ready, 0);
            chk("err_sticky", err, 1);
            itf.in_valid = 0;
            @(posedge clk); #1;
        end
    endtask
    initial begin
        vec_t rv;
        reset_n = 0; start = 0;
        itf.in_valid = 0; itf.in_data = 0; itf.in_last = 0; itf.cpu_a = 6'h2a;
        #12;
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_in_ready", itf.in_ready, 0);
        chk("rst_mem_we", itf.mem_we, 0);
        chk("rst_mem_a", itf.mem_a, 0);
        chk("rst_mem_wd", itf.mem_wd, 0);
        chk("rst_err", err, 0);
        chk("rst_word_count", word_count, 0);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        chk("idle_hold", cpu_hold, 1);
        vt[0] = '{3, 1, 0, 0, 0, 3, 64};
        vt[1] = '{4, 1, 1, 0, 0, 4, 68};
        vt[2] = '{64, 1, 0, 0, 0, 64, 64};
        vt[3] = '{1, 1, 0, 1, 0, 1, 64};
        vt[4] = '{64, 0, 0, 0, 1, 64, 64};
        vt[5] = '{63, 1, 0, 1, 0, 63, 64};
        vt[6] = '{1, 1, 0, 0, 0, 1, 64};
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 64; i++) prog[i] = $urandom;
            if (t == 0) begin
                prog[0] = 32'h20080005; prog[1] = 32'h2009000c; prog[2] = 32'h01095020;
            end
            if (t == 3) prog[0] = 32'h2402000a;
            load_and_check(vt[t]);
        end
        start = 1;
        @(posedge clk); #1;
        start = 0; itf.in_valid = 1; itf.in_data = 32'h11111111; itf.in_last = 0;
        @(posedge clk); #1;
        itf.in_data = 32'h22222222; itf.in_last = 1;
        @(posedge clk); #1;
        itf.in_valid = 0; itf.in_last = 0; start = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fill_we", itf.mem_we, 1);
        chk("fill_wd", itf.mem_wd, 0);
        chk("fill_ready", itf.in_ready, 0);
        chk("fill_word_count", word_count, 2);
        chk("fill_start_ignored", cpu_hold, 1);
        #2 reset_n = 0;
        #1;
        chk("arst_cpu_hold", cpu_hold, 1);
        chk("arst_mem_we", itf.mem_we, 0);
        chk("arst_word_count", word_count, 0);
        chk("arst_done", done, 0);
        start = 0;
        @(negedge clk) reset_n = 1;
        itf.in_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_ready", itf.in_ready, 0);
        chk("post_rst_idle_we", itf.mem_we, 0);
        chk("post_rst_idle_hold", cpu_hold, 1);
        itf.in_valid = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) prog[i] = $urandom;
            rv.n = $urandom_range(1, 64);
            rv.last = 1; rv.bub = 2; rv.junk = 1; rv.exp_err = 0;
            rv.exp_wc = rv.n; rv.exp_edges = -1;
            load_and_check(rv);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the 64-word × 32-bit writable instruction memory of the single-cycle MIPS core. It holds the core in reset while a program arrives as a valid/ready word stream, writes the words to consecutive instruction addresses, and zero-fills the unused tail with NOPs (`0x00000000`). It then hands the memory address port to the core's fetch path and releases it. It sits between the program source (testbench or debug port), the instruction RAM write/address port and the processor's PC.

## Interface
Parameters:
- `DEPTH` — 64 — number of instruction words.
- `AW` — 6 — word address width; DEPTH = 2**AW.
- `DW` — 32 — instruction width.

Ports:
- `clk` — in — 1 — single system clock, rising edge.
- `reset_n` — in — 1 — asynchronous, active-low reset.
- `start` — in — 1 — pulse that begins a (re)load; sampled on `clk`.
- `in_valid` — in — 1 — stream word valid.
- `in_data` — in — DW — stream instruction word.
- `in_last` — in — 1 — marks the final word of the program; qualified by `in_valid`.
- `in_ready` — out — 1 — loader accepts a stream word this cycle.
- `cpu_a` — in — AW — core's fetch word address (PC[7:2]).
- `mem_a` — out — AW — address to the instruction RAM.
- `mem_we` — out — 1 — RAM write enable.
- `mem_wd` — out — DW — RAM write data.
- `cpu_hold` — out — 1 — holds the core in reset while high.
- `done` — out — 1 — program loaded and core running.
- `err` — out — 1 — overflow: the stream exceeded DEPTH words.
- `word_count` — out — AW+1 — words accepted in the latest load (0..64).

## Operation
- **States:** IDLE, LOAD, FILL, RUN, ERR. All state is held in registers: state, `ptr[AW-1:0]`, `word_count`, `err`.
- **Reset:**
  - State goes to IDLE, `ptr`=0, `word_count`=0, `err`=0.
  - Outputs: `cpu_hold`=1, `done`=0, `in_ready`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- **Output decode** (combinational from state):
  - `cpu_hold` = (state != RUN).
  - `done` = (state == RUN).
  - `in_ready` = (state == LOAD).
  - `mem_a` = `cpu_a` in RUN, otherwise `ptr`.
  - `mem_we` = (LOAD & `in_valid`) | FILL.
  - `mem_wd` = `in_data` in LOAD, 0 otherwise.
- **IDLE / RUN / ERR:** `start` moves to LOAD and sets `ptr`=0, `word_count`=0, `err`=0. Otherwise the state is held.
- **LOAD:** a word is accepted when `in_valid` && `in_ready`. The RAM write happens in the same cycle, then `ptr`++ and `word_count`++. On an accept:
  - `in_last`=1 and `ptr`<63 → FILL, with `ptr`=`ptr`+1.
  - `in_last`=1 and `ptr`==63 → RUN; `ptr` wraps to 0 and is not used.
  - `in_last`=0 and `ptr`==63 → ERR, `err`=1. The word at address 63 is written; `word_count`=64.
  - `in_valid`=0 → nothing is written and the state is held.
- **FILL:** writes 0 to `ptr` every cycle, then `ptr`++. The write at `ptr`==63 moves to RUN.
- **Ignored inputs:**
  - `start` is ignored in LOAD and FILL.
  - `in_valid` and `in_last` are ignored outside LOAD.
- **ERR:** the core stays held and `in_ready`=0. Only `start` or reset exits. RAM contents are left as written.
- **Reset mid-load:** the FSM returns to IDLE at once. Partial RAM contents are not cleared; a new `start` is required.

## Timing
- `start` sampled at edge e0 → LOAD from e0. `in_ready`=1 in the cycle after e0.
- With `in_valid` held high, an N-word program (1 ≤ N ≤ 64) writes on edges e1..eN and fills on e(N+1)..e64. RUN (`cpu_hold`=0, `done`=1) is entered at e64.
- Total load time is exactly 64 write cycles plus any `in_valid` bubble cycles.
- `start` while in RUN: `cpu_hold` rises and `done` falls in the cycle after the sampling edge. `mem_a` switches from `cpu_a` to `ptr` in the same cycle.
- The write path has zero latency: `mem_we`/`mem_a`/`mem_wd` are valid in the cycle of the handshake, and the RAM captures them at the next edge.
- **Boundary cases:**
  - `start` and `in_valid` asserted together in IDLE: no word is accepted that cycle.
  - N=64 with `in_last` on word 64: no FILL cycles occur.

## Test plan
- **3-word program:** reset, `start`, stream `20080005`, `2009000c`, `01095020` with `in_last` on word 3, `in_valid` continuous.
  - Expect RAM[0..2] = those words and RAM[3..63] = 0.
  - Expect `word_count`=3, `done`=1 at e64, `mem_a` follows `cpu_a`.
- **Bubbles:** stream 4 words with `in_valid` low on alternating cycles.
  - Expect no writes in bubble cycles.
  - Expect RUN at e68 (e64 + 4 bubbles), `word_count`=4.
- **Full and overflow:**
  - 64 words with `in_last` on word 64 → RUN at e64, no FILL, `err`=0.
  - A separate run of 64 words without `in_last` → ERR, `err`=1, `word_count`=64, `cpu_hold`=1, `in_ready`=0.
- **Reload from RUN:** `start` while running → `cpu_hold`=1 the next cycle. A 1-word reload writes `0x2402000a` to address 0, fills 1..63 with 0, and returns to RUN.
- **Async reset mid-FILL:** assert `reset_n`=0 between edges → IDLE immediately, `cpu_hold`=1, `mem_we`=0, `word_count`=0. `start` during LOAD/FILL is shown to have no effect.
